// File: rtl/seq_detector_pkg.sv
// Shared constants for the 1-0-1-0-1 serial pattern detector: state width,
// Mealy/Moore state encodings and the pattern itself.
package seq_detector_pkg;

    localparam int STATE_W = 3;

    // Oldest bit in the MSB; bit 0 is the final bit that completes a match.
    localparam logic [4:0] PATTERN = 5'b10101;

    typedef enum logic [STATE_W-1:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4
    } mealy_state_e;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } moore_state_e;

endpackage

// File: rtl/seq_detector_moore_core.sv
// Moore half of the 1-0-1-0-1 detector: state register plus a glitch-free flag.
// Overlapping detection when SEQ_DETECTOR_OVERLAP_EN is defined.
module seq_detector_moore_core
    import seq_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic flag_moore
);

    moore_state_e state_q, state_d;
    logic         flag_q;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S1 : S2;
            S2:      state_d = din ? S3 : S0;
            S3:      state_d = din ? S1 : S4;
            S4:      state_d = din ? S5 : S0;
`ifdef SEQ_DETECTOR_OVERLAP_EN
            S5:      state_d = din ? S1 : S4;
`else
            S5:      state_d = din ? S1 : S0;
`endif
            default: state_d = S0;
        endcase
    end

    // Flag registered alongside the state so it is exactly "state == S5".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= (state_d == S5);
        end
    end

    assign flag_moore = flag_q;

endmodule

// File: rtl/seq_detector.sv
// Serial 1-0-1-0-1 detector with parallel Mealy (zero-latency) and Moore flags.
// Define SEQ_DETECTOR_OVERLAP_EN for overlapping detection; otherwise matched bits are not reused.
module seq_detector
    import seq_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic flag_mealy,
    output logic flag_moore
);

    mealy_state_e mealy_state_q, mealy_state_d;

    always_comb begin
        mealy_state_d = M0;
        case (mealy_state_q)
            M0:      mealy_state_d = din ? M1 : M0;
            M1:      mealy_state_d = din ? M1 : M2;
            M2:      mealy_state_d = din ? M3 : M0;
            M3:      mealy_state_d = din ? M1 : M4;
`ifdef SEQ_DETECTOR_OVERLAP_EN
            M4:      mealy_state_d = din ? M3 : M0;
`else
            M4:      mealy_state_d = M0;
`endif
            default: mealy_state_d = M0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mealy_state_q <= M0;
        end else begin
            mealy_state_q <= mealy_state_d;
        end
    end

    // Combinational on din by design: the flag rises before the completing bit is sampled.
    assign flag_mealy = !rst && (mealy_state_q == M4) && (din == PATTERN[0]);

    seq_detector_moore_core u_moore (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .flag_moore (flag_moore)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: vector table plus hand-written corner sequences.
// Expectations follow SEQ_DETECTOR_OVERLAP_EN (overlapping when defined).
module tb_seq_detector;

    logic clk;
    logic rst;
    logic din;
    logic flag_mealy;
    logic flag_moore;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst;
        logic din;
        logic exp_mealy;
        logic exp_moore;
        logic chk_moore;
    } vec_t;

    vec_t vecs[$];

    seq_detector dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .flag_mealy (flag_mealy),
        .flag_moore (flag_moore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic d, input logic em,
                                input logic emo, input logic cm = 1'b1);
        vec_t v;
        v.rst = r;
        v.din = d;
        v.exp_mealy = em;
        v.exp_moore = emo;
        v.chk_moore = cm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive one bit in the low phase and check both flags before the next rising edge.
    task automatic step(input string nm, input logic r, input logic d,
                        input logic em, input logic emo);
        @(negedge clk);
        rst = r;
        din = d;
        #1;
        check({nm, "_mealy"}, flag_mealy, em);
        check({nm, "_moore"}, flag_moore, emo);
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b1;

        // Reset with din=1; Moore flag unknown in the very first cycle.
        add(1, 1, 0, 0, 0);
        // Held reset while the pattern streams by: nothing fires.
        add(1, 1, 0, 0);
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);
        add(1, 0, 0, 0);
        add(1, 1, 0, 0);

        // Basic detection.
        add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        add(0, 1, 1, 0);
        add(0, 0, 0, 1);
        add(1, 0, 0, 0);

`ifdef SEQ_DETECTOR_OVERLAP_EN
        // 17 alternating bits: Mealy on 5,7,..,17, Moore one cycle later.
        for (int i = 1; i <= 18; i++) begin
            add(0, (i % 2 == 1) && (i <= 17),
                (i >= 5) && (i % 2 == 1) && (i <= 17),
                (i >= 6) && (i % 2 == 0));
        end
`else
        // 11 alternating bits: hits on bits 5 and 11 only.
        for (int i = 1; i <= 12; i++) begin
            add(0, (i % 2 == 1) && (i <= 11),
                (i == 5) || (i == 11),
                (i == 6) || (i == 12));
        end
`endif
        add(1, 0, 0, 0);

        // No false hits.
        add(0, 1, 0, 0);
        add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        add(0, 1, 0, 0);
        add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        add(0, 0, 0, 0);
        add(0, 1, 0, 0);
        add(0, 1, 0, 0);
        add(0, 0, 0, 0);
        add(1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            din = vecs[i].din;
            #1;
            check($sformatf("vec%0d_mealy", i), flag_mealy, vecs[i].exp_mealy);
            if (vecs[i].chk_moore)
                check($sformatf("vec%0d_moore", i), flag_moore, vecs[i].exp_moore);
        end

        // Mid-sequence reset discards the 1,0,1,0 prefix.
        step("mid_a", 0, 1, 0, 0);
        step("mid_b", 0, 0, 0, 0);
        step("mid_c", 0, 1, 0, 0);
        step("mid_d", 0, 0, 0, 0);
        step("mid_rst", 1, 1, 0, 0);
        step("mid_e", 0, 1, 0, 0);
        step("mid_f", 0, 0, 0, 0);
        step("mid_g", 0, 1, 0, 0);
        step("mid_h", 0, 0, 0, 0);
        step("mid_hit", 0, 1, 1, 0);
        step("mid_after", 0, 0, 0, 1);
        step("mid_clr", 1, 0, 0, 0);

        // Within one cycle in prefix "1010": Mealy follows din, reset masks it.
        step("gl_a", 0, 1, 0, 0);
        step("gl_b", 0, 0, 0, 0);
        step("gl_c", 0, 1, 0, 0);
        step("gl_d", 0, 0, 0, 0);
        step("gl_lo", 0, 0, 0, 0);
        din = 1'b1;
        #1;
        check("gl_hi_mealy", flag_mealy, 1'b1);
        rst = 1'b1;
        #1;
        check("gl_rst_mask", flag_mealy, 1'b0);
        rst = 1'b0;
        din = 1'b0;
        #1;
        check("gl_back_lo", flag_mealy, 1'b0);
        check("gl_back_moore", flag_moore, 1'b0);
        // din=0 sampled in "1010" drops the match; a following 1 must not fire.
        step("gl_after", 0, 1, 0, 0);
        step("gl_after2", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
